// File: rtl/dist_sync_fifo_pkg.sv
// Shared types and elaboration helpers for the distributed-RAM synchronous FIFO.
// Holds the flag bundle, its reset value, the count-width rule and the parameter range check.
package dist_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t RST_FLAGS = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  // One extra bit so that a completely full buffer is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit params_ok(input int addr_width, input int data_width,
                                   input int almost_full_num, input int almost_empty_num);
    int depth;
    depth = 1 << addr_width;
    return (addr_width >= 4) && (addr_width <= 10) &&
           (data_width >= 1) && (data_width <= 256) &&
           (almost_full_num >= 1) && (almost_full_num <= depth) &&
           (almost_empty_num >= 0) && (almost_empty_num <= depth - 1);
  endfunction

endpackage

// File: rtl/dist_sync_fifo_if.sv
// Write/read handshake and status bundle of dist_sync_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface dist_sync_fifo_if
  import dist_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);

  logic                               wr_en;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               rd_en;
  logic [DATA_WIDTH-1:0]              rd_data;
  logic                               rd_valid;
  logic                               full;
  logic                               empty;
  logic                               almost_full;
  logic                               almost_empty;
  logic [count_width(ADDR_WIDTH)-1:0] count;
  logic                               overflow;
  logic                               underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/dist_sync_fifo_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous (combinational) read.
module dist_ram_sdp #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "distributed" *)
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the storage array has no reset; resetting it would turn the RAM into plain flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dist_sync_fifo.sv
// Single-clock FIFO on distributed RAM with count, almost flags and overflow/underflow strobes.
// Define DIST_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module dist_sync_fifo
  import dist_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input logic             clk,
  input logic             rst,
  dist_sync_fifo_if.slave bus
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] AF_LVL = CW'(ALMOST_FULL_NUM);
  localparam logic [CW-1:0] AE_LVL = CW'(ALMOST_EMPTY_NUM);

  if (!params_ok(ADDR_WIDTH, DATA_WIDTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_bad_params
    $fatal(1, "dist_sync_fifo: parameter out of range");
  end

  logic [CW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt, count_q;
  logic                  wr_accept, rd_accept;
  fifo_flags_t           flags, flags_nxt;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // NOTE: every combinational output is assigned on every pass, so no latch can be inferred.
  always_comb begin
    wr_accept  = bus.wr_en && !flags.full;
    rd_accept  = bus.rd_en && !flags.empty;
    wr_ptr_nxt = wr_ptr + CW'(wr_accept);
    rd_ptr_nxt = rd_ptr + CW'(rd_accept);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    flags_nxt.full         = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                             (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
    flags_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
    flags_nxt.almost_full  = (count_nxt >= AF_LVL);
    flags_nxt.almost_empty = (count_nxt <= AE_LVL);
    flags_nxt.overflow     = bus.wr_en && flags.full;
    flags_nxt.underflow    = bus.rd_en && flags.empty;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      flags   <= RST_FLAGS;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      flags   <= flags_nxt;
    end
  end

  dist_ram_sdp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

`ifdef DIST_FIFO_FWFT_EN
  // Head word is shown straight from the RAM; rd_en acknowledges it.
  assign bus.rd_data  = ram_rdata;
  assign bus.rd_valid = !flags.empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= ram_rdata;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = flags.full;
  assign bus.empty        = flags.empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.overflow     = flags.overflow;
  assign bus.underflow    = flags.underflow;
  assign bus.count        = count_q;

endmodule
